// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the multi-cycle ALU and the decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_SRA = 3'b100,
    OP_SRL = 3'b101,
    OP_SLL = 3'b110,
    OP_REM = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIVB = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // DIV and REM share the iterative divider; everything else is single-cycle.
  function automatic logic is_div_op(input alu_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first iteration is folded into the start cycle so WIDTH iterations
// finish WIDTH-1 cycles after start, letting the top capture on the next edge.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_dsr;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // One restoring step, fed from the fresh operands on start or from the shift registers otherwise.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dsr  = start ? divisor : dsr_q;
    partial  = {src_rem, src_quo[WIDTH-1]};
    trial    = partial - {1'b0, src_dsr};
    step_rem = trial[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], 1'b1};
    if (trial[WIDTH]) begin
      step_rem = partial[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration counter and shift registers; start always wins so back-to-back divides work.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= step_rem;
      quo_q  <= step_quo;
      dsr_q  <= divisor;
      cnt_q  <= CNT_W'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake on both sides and an iterative divider.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagD
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q;
  alu_state_t       state_d;
  alu_op_t          op_in;
  alu_op_t          op_q;
  logic             lt_q;

  logic             accept;
  logic             b_zero;
  logic             in_is_div;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic             div_finish;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic [WIDTH-1:0] div_result;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick_result;

  assign op_in      = alu_op_t'(sel);
  assign b_zero     = (B == '0);
  assign in_is_div  = is_div_op(op_in);
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign div_start  = accept && in_is_div && !b_zero;
  assign div_finish = (state_q == DIVB) && div_busy && div_done;
  assign div_result = (op_q == OP_REM) ? div_remainder : div_quotient;
  assign shamt      = B[SHW-1:0];
  assign out_valid  = (state_q == DONE);

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (A),
    .divisor   (B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Single-cycle datapath, including the divide-by-zero shortcut results.
  always_comb begin
    quick_result = '0;
    unique case (op_in)
      OP_ADD: quick_result = A + B;
      OP_SUB: quick_result = A - B;
      OP_MUL: quick_result = A * B;
      OP_DIV: quick_result = '1;
      OP_SRA: quick_result = $unsigned($signed(A) >>> shamt);
      OP_SRL: quick_result = A >> shamt;
      OP_SLL: quick_result = A << shamt;
      OP_REM: quick_result = A;
      default: quick_result = '0;
    endcase
  end

  // Next-state logic: accepts route to DIVB only for a real divide, otherwise straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = div_start ? DIVB : DONE;
      end
      DIVB: begin
        if (div_finish) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = div_start ? DIVB : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Per-transaction context kept across the divide so the flags match the captured operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_ADD;
      lt_q <= 1'b0;
    end else if (accept) begin
      op_q <= op_in;
      lt_q <= (A < B);
    end
  end

  // Result and flag registers, loaded together either at accept or when the divider finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      C     <= '0;
      flagZ <= 1'b0;
      flagN <= 1'b0;
      flagD <= 1'b0;
    end else if (accept && !div_start) begin
      C     <= quick_result;
      flagZ <= (quick_result == '0);
      flagN <= (A < B);
      flagD <= in_is_div && b_zero;
    end else if (div_finish) begin
      C     <= div_result;
      flagZ <= (div_result == '0);
      flagN <= lt_q;
      flagD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle plus handshake and reset corner cases.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             flagZ;
  logic             flagN;
  logic             flagD;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        z;
    logic        n;
    logic        d;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .flagZ     (flagZ),
    .flagN     (flagN),
    .flagD     (flagD)
  );

  function automatic vec_t mk(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic z, input logic n, input logic d,
                              input int lat);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.c = c; v.z = z; v.n = n; v.d = d; v.lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for exactly one edge, then scramble the inputs so only captured values matter.
  task automatic applyStimulus(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    sel = s; A = a; B = b; in_valid = 1'b1;
    #1;
    checkOutput("in_ready before accept", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    sel = ~s; A = ~a; B = 32'h0;
  endtask

  task automatic waitResult(input int limit, output int lat);
    int edges;
    edges = 0;
    while (!out_valid && edges < limit) begin
      tick();
      edges++;
    end
    lat = out_valid ? edges + 1 : -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int lat;
    applyStimulus(v.sel, v.a, v.b);
    if (v.lat > 1)
      checkOutput($sformatf("vec%0d in_ready while dividing", idx), {31'b0, in_ready}, 32'd0);
    waitResult(WIDTH + 8, lat);
    checkOutput($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
    checkOutput($sformatf("vec%0d C", idx), C, v.c);
    checkOutput($sformatf("vec%0d flags ZND", idx), {29'b0, flagZ, flagN, flagD}, {29'b0, v.z, v.n, v.d});
    consume();
    checkOutput($sformatf("vec%0d out_valid after consume", idx), {31'b0, out_valid}, 32'd0);
  endtask

  // Watchdog so the run always ends even if a handshake wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int lat;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 3'b0; A = '0; B = '0;

    vecs.push_back(mk(OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1));
    vecs.push_back(mk(OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 0, 1, 0, 1));
    vecs.push_back(mk(OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 0, 1, 0, 1));
    vecs.push_back(mk(OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLL, 32'h1,         32'hFFFF_FFE3, 32'h8,         0, 1, 0, 1));
    vecs.push_back(mk(OP_DIV, 32'd100,       32'd7,         32'd14,        0, 0, 0, WIDTH + 1));
    vecs.push_back(mk(OP_REM, 32'd100,       32'd7,         32'd2,         0, 0, 0, WIDTH + 1));
    vecs.push_back(mk(OP_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0, 1, 1));
    vecs.push_back(mk(OP_REM, 32'd5,         32'd0,         32'd5,         0, 0, 1, 1));
    vecs.push_back(mk(OP_DIV, 32'd7,         32'd100,       32'd0,         1, 1, 0, WIDTH + 1));
    vecs.push_back(mk(OP_REM, 32'hFFFF_FFFF, 32'h10,        32'hF,         0, 0, 0, WIDTH + 1));
    vecs.push_back(mk(OP_DIV, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 0, 0, 0, WIDTH + 1));
    vecs.push_back(mk(OP_DIV, 32'd1000,      32'd3,         32'd333,       0, 0, 0, WIDTH + 1));
    vecs.push_back(mk(OP_ADD, 32'h0,         32'h0,         32'h0,         1, 0, 0, 1));

    repeat (2) tick();
    rst = 1'b0;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset C", C, 32'h0);
    checkOutput("reset flags ZND", {29'b0, flagZ, flagN, flagD}, 32'd0);

    foreach (vecs[i]) runVector(vecs[i], i);

    // Backpressure: result must hold while out_ready is low.
    applyStimulus(OP_SUB, 32'd9, 32'd2);
    waitResult(WIDTH + 8, lat);
    checkOutput("bp latency", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("bp hold C", C, 32'd7);
      checkOutput("bp hold flags/valid", {28'b0, out_valid, flagZ, flagN, flagD}, 32'b1000);
      checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
    end

    // Back-to-back: release and accept ADD 2+3 on the same edge.
    out_ready = 1'b1; sel = OP_ADD; A = 32'd2; B = 32'd3; in_valid = 1'b1;
    #1;
    checkOutput("b2b in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0;
    checkOutput("b2b out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b C", C, 32'd5);
    checkOutput("b2b flags ZND", {29'b0, flagZ, flagN, flagD}, 32'b010);

    // Back-to-back from DONE straight into a divide.
    out_ready = 1'b1; sel = OP_REM; A = 32'd100; B = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; A = 32'h0; B = 32'h0;
    checkOutput("b2b div out_valid low", {31'b0, out_valid}, 32'd0);
    checkOutput("b2b div in_ready low", {31'b0, in_ready}, 32'd0);
    waitResult(WIDTH + 8, lat);
    checkOutput("b2b div latency", 32'(lat), 32'(WIDTH + 1));
    checkOutput("b2b div C", C, 32'd2);
    consume();

    // Reset during the tenth divider iteration aborts the op.
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("abort C", C, 32'h0);
    seen = 0;
    repeat (WIDTH + 8) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("abort no result", 32'(seen), 32'd0);

    applyStimulus(OP_SUB, 32'd3, 32'd5);
    waitResult(WIDTH + 8, lat);
    checkOutput("post-abort latency", 32'(lat), 32'd1);
    checkOutput("post-abort C", C, 32'hFFFF_FFFE);
    checkOutput("post-abort flags ZND", {29'b0, flagZ, flagN, flagD}, 32'b010);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
